// File: rtl/dram_cmd_responder_pkg.sv
// rtl/dram_cmd_responder_pkg.sv - command encodings, FSM states and geometry shared with dram_controller
package dram_pkg;

  localparam int NUMBER_OF_COLUMNS = 8;
  localparam int NUMBER_OF_ROWS    = 128;
  localparam int NUMBER_OF_BANKS   = 8;
  localparam int DRAM_DATA_WIDTH   = 2;
  localparam int CAS_LATENCY_DEF   = 2;
  localparam int REFRESH_CYCLES_DEF = 4;

  localparam int COLUMN_WIDTH    = $clog2(NUMBER_OF_COLUMNS / DRAM_DATA_WIDTH);
  localparam int ROW_WIDTH       = $clog2(NUMBER_OF_ROWS);
  localparam int BANK_ID_WIDTH   = $clog2(NUMBER_OF_BANKS);
  localparam int DRAM_ADDR_WIDTH = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_REFRESH = 1'b1
  } state_e;

endpackage

// File: rtl/dram_cmd_responder_if.sv
// rtl/dram_cmd_responder_if.sv - DRAM command/data bus between controller (master) and responder (slave)
interface dram_cmd_responder_if;
  import dram_pkg::*;

  logic                       dram_clk_en;
  logic                       dram_cs_n;
  logic                       dram_ras_n;
  logic                       dram_cas_n;
  logic                       dram_we_n;
  logic [BANK_ID_WIDTH-1:0]   dram_bank_id;
  logic [DRAM_ADDR_WIDTH-1:0] dram_addr;
  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data;
  logic [DRAM_DATA_WIDTH-1:0] dram_rd_data;
  logic                       dram_refresh_done;
  logic                       dram_proto_err;

  modport master (
    output dram_clk_en, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
    output dram_bank_id, dram_addr, dram_wr_data,
    input  dram_rd_data, dram_refresh_done, dram_proto_err
  );

  modport slave (
    input  dram_clk_en, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
    input  dram_bank_id, dram_addr, dram_wr_data,
    output dram_rd_data, dram_refresh_done, dram_proto_err
  );

endinterface

// File: rtl/dram_read_pipe.sv
// rtl/dram_read_pipe.sv - CAS-latency shift register of {valid, data} with clock-enable stall
module dram_read_pipe
  import dram_pkg::*;
#(
  parameter int DEPTH = CAS_LATENCY_DEF,
  parameter int WIDTH = DRAM_DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             busy_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      rd_q  <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else if (en_i) begin
      vld_q[0] <= push_i;
      dat_q[0] <= push_data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      // output register holds the last retired read until the next one
      if (vld_q[DEPTH-1]) rd_q <= dat_q[DEPTH-1];
    end
  end

  assign rd_data_o = rd_q;
  assign busy_o    = |vld_q;

endmodule

// File: rtl/dram_cmd_responder.sv
// rtl/dram_cmd_responder.sv - DRAM device model: command decode, bank/row storage, CAS read pipe, refresh
// Optional DRAM_PROTOCOL_CHECK_EN enables the sticky dram_proto_err flag and violation messages.
module dram_cmd_responder
  import dram_pkg::*;
#(
  parameter int CAS_LATENCY    = CAS_LATENCY_DEF,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
  input logic                 dram_clk,
  input logic                 dram_rst_n,
  dram_cmd_responder_if.slave bus
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [3:0]                 cmd;
  logic [BANK_ID_WIDTH-1:0]   bank;
  logic [COLUMN_WIDTH-1:0]    col;
  logic [ROW_WIDTH-1:0]       row_in;
  logic [ROW_WIDTH-1:0]       open_row;
  logic                       bank_act;
  logic                       pipe_busy;
  logic [DRAM_DATA_WIDTH-1:0] rd_slice;
  logic [DRAM_DATA_WIDTH-1:0] rd_data;
  logic do_act, do_rd, do_wr, do_pre, do_ref, viol, done_d, done_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUMBER_OF_BANKS-1:0]   bank_active_q;
  logic [ROW_WIDTH-1:0]         open_row_q [NUMBER_OF_BANKS];
  logic [NUMBER_OF_COLUMNS-1:0] mem_q [NUMBER_OF_BANKS][NUMBER_OF_ROWS];

  assign cmd      = bus.dram_cs_n ? CMD_NOP : {1'b0, bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n};
  assign bank     = bus.dram_bank_id;
  assign col      = bus.dram_addr[COLUMN_WIDTH-1:0];
  assign row_in   = bus.dram_addr[ROW_WIDTH-1:0];
  assign bank_act = bank_active_q[bank];
  assign open_row = open_row_q[bank];
  assign rd_slice = mem_q[bank][open_row][col*DRAM_DATA_WIDTH +: DRAM_DATA_WIDTH];

  always_ff @(posedge dram_clk) begin
    if (!dram_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.dram_clk_en) begin
      case (state_q)
        ST_IDLE: if (do_ref) begin
          state_d = ST_REFRESH;
          cnt_d   = CNT_W'(REFRESH_CYCLES - 1);
        end
        ST_REFRESH: if (cnt_q == '0) state_d = ST_IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    do_act = 1'b0;
    do_rd  = 1'b0;
    do_wr  = 1'b0;
    do_pre = 1'b0;
    do_ref = 1'b0;
    viol   = 1'b0;
    done_d = 1'b0;
    if (bus.dram_clk_en) begin
      if (state_q == ST_IDLE) begin
        case (cmd)
          CMD_NOP: ;
          CMD_ACT: if (bank_act) viol = 1'b1; else do_act = 1'b1;
          CMD_RD:  if (bank_act) do_rd = 1'b1; else viol = 1'b1;
          CMD_WR:  if (bank_act) do_wr = 1'b1; else viol = 1'b1;
          CMD_PRE: do_pre = 1'b1;
          CMD_REF: if (|bank_active_q || pipe_busy) viol = 1'b1; else do_ref = 1'b1;
          default: viol = 1'b1;
        endcase
      end else begin
        viol   = (cmd != CMD_NOP);
        done_d = (cnt_q == '0);
      end
    end
  end

  // ACTIVATE and PRECHARGE are mutually exclusive commands, so at most one bank update per cycle
  always_ff @(posedge dram_clk) begin
    if (!dram_rst_n) begin
      bank_active_q <= '0;
      for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
        open_row_q[b] <= '0;
        for (int r = 0; r < NUMBER_OF_ROWS; r++) mem_q[b][r] <= '0;
      end
    end else begin
      if (do_act) begin
        bank_active_q[bank] <= 1'b1;
        open_row_q[bank]    <= row_in;
      end
      if (do_pre) bank_active_q[bank] <= 1'b0;
      if (do_wr) mem_q[bank][open_row][col*DRAM_DATA_WIDTH +: DRAM_DATA_WIDTH] <= bus.dram_wr_data;
    end
  end

  dram_read_pipe #(
    .DEPTH (CAS_LATENCY),
    .WIDTH (DRAM_DATA_WIDTH)
  ) u_read_pipe (
    .clk_i       (dram_clk),
    .rst_ni      (dram_rst_n),
    .en_i        (bus.dram_clk_en),
    .push_i      (do_rd),
    .push_data_i (rd_slice),
    .rd_data_o   (rd_data),
    .busy_o      (pipe_busy)
  );

  assign bus.dram_rd_data      = rd_data;
  assign bus.dram_refresh_done = done_q;

`ifdef DRAM_PROTOCOL_CHECK_EN
  logic proto_err_q;

  always_ff @(posedge dram_clk) begin
    if (!dram_rst_n) proto_err_q <= 1'b0;
    else if (viol)   proto_err_q <= 1'b1;
  end

`ifndef SYNTHESIS
  always @(posedge dram_clk) begin
    if (dram_rst_n && viol)
      $display("%0t dram_cmd_responder: protocol violation cmd=%b bank=%0d", $time, cmd, bank);
  end
`endif

  assign bus.dram_proto_err = proto_err_q;
`else
  logic unused_viol;
  assign unused_viol        = viol;
  assign bus.dram_proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_cmd_responder.sv
// tb/tb_dram_cmd_responder.sv - scoreboard bench for dram_cmd_responder
module tb_dram_cmd_responder;
  import dram_pkg::*;

`ifdef DRAM_PROTOCOL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    int                         cnt;
    logic [DRAM_DATA_WIDTH-1:0] data;
  } sb_t;

  sb_t  sb[$];
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   err_seen = 1'b0;

  dram_cmd_responder_if bus();

  dram_cmd_responder dut (
    .dram_clk   (clk),
    .dram_rst_n (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sb.delete();
    end else if (bus.dram_clk_en) begin
      foreach (sb[i]) sb[i].cnt--;
      if (sb.size() > 0 && sb[0].cnt == 0) begin
        chk("rd_data", 32'(bus.dram_rd_data), 32'(sb[0].data));
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic drive(input logic [3:0] c, input int b, input int a, input logic [DRAM_DATA_WIDTH-1:0] d);
    {bus.dram_cs_n, bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = c;
    bus.dram_bank_id = BANK_ID_WIDTH'(b);
    bus.dram_addr    = DRAM_ADDR_WIDTH'(a);
    bus.dram_wr_data = d;
    tick();
  endtask

  task automatic nop();                   drive(CMD_NOP, 0, 0, '0);   endtask
  task automatic act(input int b, input int r); drive(CMD_ACT, b, r, '0); endtask
  task automatic pre(input int b);        drive(CMD_PRE, b, 0, '0);   endtask
  task automatic wr(input int b, input int c, input logic [DRAM_DATA_WIDTH-1:0] d); drive(CMD_WR, b, c, d); endtask

  task automatic rd(input int b, input int c, input logic [DRAM_DATA_WIDTH-1:0] exp);
    sb_t e;
    e.cnt  = CAS_LATENCY_DEF + 1;
    e.data = exp;
    sb.push_back(e);
    drive(CMD_RD, b, c, '0);
  endtask

  task automatic illegal(input logic [3:0] c, input int b, input int a);
    err_seen = 1'b1;
    drive(c, b, a, '0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      nop();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic chk_err(input string tag);
    chk(tag, 32'(bus.dram_proto_err), 32'(CHK_EN && err_seen));
  endtask

  initial begin
    bus.dram_clk_en = 1'b1;
    {bus.dram_cs_n, bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = CMD_NOP;
    bus.dram_bank_id = '0;
    bus.dram_addr    = '0;
    bus.dram_wr_data = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_rd_data", 32'(bus.dram_rd_data), 32'd0);
    chk("reset_done", 32'(bus.dram_refresh_done), 32'd0);
    chk("reset_err", 32'(bus.dram_proto_err), 32'd0);

    // write then read at CAS latency
    act(3, 'h45);
    wr(3, 2, 2'b10);
    rd(3, 2, 2'b10);
    drain();
    nop();
    chk("rd_hold", 32'(bus.dram_rd_data), 32'h2);
    chk_err("err_clean");

    // read of idle bank and re-activate of active bank are both ignored
    illegal(CMD_RD, 5, 2);
    repeat (3) nop();
    chk("rd_unchanged", 32'(bus.dram_rd_data), 32'h2);
    chk_err("err_rd_idle");
    illegal(CMD_ACT, 3, 'h46);
    rd(3, 2, 2'b10);
    drain();
    chk_err("err_act_active");

    // row isolation
    pre(3);
    act(3, 'h46);
    rd(3, 2, 2'b00);
    drain();
    pre(3);

    // back-to-back reads retire on consecutive cycles
    act(0, 1);
    wr(0, 0, 2'b01);
    wr(0, 1, 2'b10);
    wr(0, 2, 2'b11);
    wr(0, 3, 2'b00);
    rd(0, 0, 2'b01);
    rd(0, 1, 2'b10);
    rd(0, 2, 2'b11);
    rd(0, 3, 2'b00);
    drain();
    pre(0);

    // refresh: one-cycle done pulse, read during refresh ignored, command on pulse decoded
    drive(CMD_REF, 0, 0, '0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 1)      illegal(CMD_RD, 0, 0);
      else if (k == 5) act(1, 2);
      else             nop();
      chk($sformatf("ref_done_%0d", k), 32'(bus.dram_refresh_done), 32'(k == 4));
    end
    chk_err("err_rd_in_ref");
    wr(1, 1, 2'b11);
    wr(1, 0, 2'b01);
    rd(1, 1, 2'b11);
    drain();

    // clock-enable stall delays the read
    rd(1, 0, 2'b01);
    bus.dram_clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nop();
      chk("stall_hold", 32'(bus.dram_rd_data), 32'h3);
    end
    bus.dram_clk_en = 1'b1;
    drain();

    // reset in the middle of a refresh
    pre(1);
    drive(CMD_REF, 0, 0, '0);
    nop();
    nop();
    rst_n = 1'b0;
    nop();
    rst_n = 1'b1;
    err_seen = 1'b0;
    chk("rst_rd_data", 32'(bus.dram_rd_data), 32'd0);
    chk_err("rst_err");
    for (int k = 0; k < 6; k++) begin
      nop();
      chk("rst_no_done", 32'(bus.dram_refresh_done), 32'd0);
    end
    act(1, 2);
    rd(1, 1, 2'b00);
    drain();
    chk_err("err_final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dram_cmd_responder.md
Name: dram_cmd_responder

Overview:
Device-side responder for the DRAM command interface driven by dram_controller. It decodes cs_n/ras_n/cas_n/we_n strobes, tracks open rows per bank, and stores write data. It returns read data after a fixed CAS latency and executes refresh with a one-cycle completion pulse. It is a synthesizable bank/row/column storage model and the bench-side counterpart to the controller.

Parameters:
- NUMBER_OF_COLUMNS, 8: bits per row.
- NUMBER_OF_ROWS, 128: rows per bank.
- NUMBER_OF_BANKS, 8: banks.
- DRAM_DATA_WIDTH, 2: bits per column access.
- CAS_LATENCY, 2: cycles from READ sample to data (1..7).
- REFRESH_CYCLES, 4: cycles a refresh occupies (>=1).
- Derived, never overridden:
  - COLUMN_WIDTH = clog2(NUMBER_OF_COLUMNS/DRAM_DATA_WIDTH)
  - ROW_WIDTH = clog2(NUMBER_OF_ROWS)
  - BANK_ID_WIDTH = clog2(NUMBER_OF_BANKS)
  - DRAM_ADDR_WIDTH = max(ROW_WIDTH, COLUMN_WIDTH)

Ports:
- dram_clk, input, 1: single clock, all logic on rising edge.
- dram_rst_n, input, 1: reset, synchronous, active-low.
- dram_clk_en, input, 1: when 0, command decode, read pipe and refresh counter all freeze.
- dram_cs_n, input, 1: chip select; 1 means deselect, treated as NOP.
- dram_ras_n, input, 1: row address strobe.
- dram_cas_n, input, 1: column address strobe.
- dram_we_n, input, 1: write enable.
- dram_bank_id, input, BANK_ID_WIDTH: target bank.
- dram_addr, input, DRAM_ADDR_WIDTH: row address (ACTIVATE) or column address in the low COLUMN_WIDTH bits (READ/WRITE).
- dram_wr_data, input, DRAM_DATA_WIDTH: write data, sampled together with the WRITE command.
- dram_rd_data, output, DRAM_DATA_WIDTH: read data.
- dram_refresh_done, output, 1: one-cycle pulse when a refresh completes.
- dram_proto_err, output, 1: sticky protocol-violation flag.

Behaviour:
- Reset (dram_rst_n=0 at an edge):
  - Storage cleared to 0; all banks idle; read pipe emptied; refresh counter reset.
  - dram_rd_data=0, dram_refresh_done=0, dram_proto_err=0.
  - Reset applied mid-read or mid-refresh aborts it: no data, no done pulse.
- Command decode on {cs_n,ras_n,cas_n,we_n}, only when clk_en=1:
  - 1xxx, 0111: NOP.
  - 0011: ACTIVATE.
  - 0101: READ.
  - 0100: WRITE.
  - 0010: PRECHARGE.
  - 0001: REFRESH.
  - 0110, 0000: NOP plus error.
- States: IDLE and REFRESH.
- ACTIVATE:
  - Bank idle: mark it active, latch open_row[bank] = addr[ROW_WIDTH-1:0].
  - Bank already active: ignored, error.
- WRITE:
  - Requires the bank to be active.
  - Writes row open_row[bank] of that bank, bits [col*DRAM_DATA_WIDTH +: DRAM_DATA_WIDTH] = wr_data.
  - Takes effect at the sampling edge.
  - Bank idle: ignored, error.
- READ:
  - Requires the bank to be active.
  - The addressed slice is captured into the read pipe at sampling edge N.
  - dram_rd_data updates at edge N+CAS_LATENCY and holds until the next read retires.
  - Back-to-back READs each retire in order, one per cycle.
  - A READ in the cycle after a WRITE to the same column returns the new data.
  - Bank idle: ignored, error, nothing enters the pipe.
- PRECHARGE: bank becomes idle. Precharging an idle bank is a legal no-op.
- REFRESH:
  - Legal only in IDLE with all banks idle and the read pipe empty. Otherwise ignored, error.
  - On entry the counter loads REFRESH_CYCLES-1 and the state becomes REFRESH.
  - The counter decrements on clk_en cycles. At 0 the state returns to IDLE and dram_refresh_done=1 for exactly that one cycle.
  - Storage is unchanged by refresh.
  - Any non-NOP command during REFRESH is ignored, error.
- Simultaneous events:
  - A read retiring and a new READ issuing in the same cycle are both honoured.
  - The done pulse and a new command in the same cycle: the command is decoded in IDLE.
- clk_en=0: outputs hold, the done pulse is not extended or emitted, and no state advances.

Optional Feature:
- Macro: DRAM_PROTOCOL_CHECK_EN.
- Defined:
  - Violations set dram_proto_err (sticky until reset).
  - Each violation also issues a simulation-only $display with time, command, bank.
- Undefined:
  - dram_proto_err tied 0, no checking logic.
  - Illegal commands are still ignored exactly as above.

Decomposition:
- Package dram_pkg:
  - command encodings (CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF as 4-bit constants);
  - state encoding;
  - width-derivation constants shared with dram_controller.
- Sub-module dram_read_pipe: CAS_LATENCY-deep shift register of {valid, data}, with a clk_en stall.

Test Plan:
1. ACT bank 3 row 0x45; WR col 2 data 2'b10; RD col 2 at edge N -> rd_data=2'b10 at edge N+2; proto_err=0.
2. REFRESH with all banks idle, REFRESH_CYCLES=4 -> done=1 for exactly one cycle 4 cycles later; a RD issued during refresh is ignored and proto_err=1.
3. RD to idle bank 5 -> rd_data unchanged, proto_err=1; ACT of already-active bank 3 -> open_row stays 0x45.
4. ACT bank 0 row 1; WR cols 0..3 with 01,10,11,00; four back-to-back RDs -> rd_data sequence 01,10,11,00 on consecutive cycles starting at N+2.
5. Hold clk_en=0 for 3 cycles mid-read -> data appears 3 cycles late; reset asserted mid-refresh -> no done pulse, rd_data=0, and a previously written cell reads 0.
6. PRE bank 3, ACT bank 3 row 0x46, RD col 2 -> 2'b00, confirming row isolation from row 0x45.
